// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU controller: decode, 8-entry register file, req/ack to ALU, writeback.
// Optional ALU_TIMEOUT_EN macro adds a request watchdog of TIMEOUT_CYC cycles.
module alu_issue_ctrl #(
    parameter int DATA_W      = 19,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid_i,
    input  logic [DATA_W-1:0] instr_i,
    output logic              instr_ready_o,
    output logic              alu_req_o,
    output logic [4:0]        alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic              alu_ack_i,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              done_o,
    output logic              illegal_o,
    output logic              timeout_o,
    input  logic [2:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB
    } state_e;

    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
    } fields_t;

    localparam logic [4:0] OP_NOT  = 5'd0;
    localparam logic [4:0] OP_INC  = 5'd8;
    localparam logic [4:0] OP_DEC  = 5'd9;
    localparam logic [4:0] OP_LAST = 5'd9;

    state_e            state_q, state_d;
    fields_t           f_q, f_d;
    fields_t           f_in;
    logic [DATA_W-1:0] res_q, res_d;
    logic              illegal_q, illegal_d;
    logic              wr_en;
    logic              in_legal;
    logic              b_zero;
    logic [DATA_W-1:0] rf_q [8];

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[4:0];

    assign f_in.op  = instr_i[18:14];
    assign f_in.rd  = instr_i[13:11];
    assign f_in.rs1 = instr_i[10:8];
    assign f_in.rs2 = instr_i[7:5];

    assign in_legal = (f_in.op <= OP_LAST);

    // Unary ops ignore rs2 so the ALU always sees a zero B operand.
    always_comb begin
        b_zero = 1'b0;
        unique case (1'b1)
            (f_q.op == OP_NOT): b_zero = 1'b1;
            (f_q.op == OP_INC): b_zero = 1'b1;
            (f_q.op == OP_DEC): b_zero = 1'b1;
            default:            b_zero = 1'b0;
        endcase
    end

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`endif

    always_comb begin
        state_d       = state_q;
        f_d           = f_q;
        res_d         = res_q;
        illegal_d     = 1'b0;
        wr_en         = 1'b0;
        instr_ready_o = 1'b0;
        alu_req_o     = 1'b0;
        alu_op_o      = 5'd0;
        alu_a_o       = '0;
        alu_b_o       = '0;
        done_o        = 1'b0;
`ifdef ALU_TIMEOUT_EN
        cnt_d         = '0;
        to_d          = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    f_d = f_in;
                    if (in_legal) begin
                        state_d = S_REQ;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                alu_req_o = 1'b1;
                alu_op_o  = f_q.op;
                alu_a_o   = rf_q[f_q.rs1];
                alu_b_o   = b_zero ? '0 : rf_q[f_q.rs2];
                if (alu_ack_i) begin
                    res_d   = alu_result_i;
                    state_d = S_WB;
`ifdef ALU_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_WB: begin
                done_o  = 1'b1;
                wr_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            f_q       <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    // r0 is hardwired to zero by never writing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en && (f_q.rd != 3'd0)) begin
            rf_q[f_q.rd] <= res_q;
        end
    end

`ifdef ALU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign illegal_o  = illegal_q;
    assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_W, 19, instruction and operand width.
REQ-002 Parameter TIMEOUT_CYC, 16, cycles alu_req_o may wait for alu_ack_i (used only with ALU_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_valid_i  input  1  instruction offered.
REQ-006 instr_i  input  DATA_W  instruction: [18:14] opcode, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] ignored.
REQ-007 instr_ready_o  output  1  block accepts instruction this cycle.
REQ-008 alu_req_o  output  1  operation presented to ALU.
REQ-009 alu_op_o  output  5  opcode to ALU.
REQ-010 alu_a_o, alu_b_o  output  DATA_W each  operands to ALU.
REQ-011 alu_ack_i  input  1  ALU result valid.
REQ-012 alu_result_i  input  DATA_W  ALU result.
REQ-013 done_o  output  1  one-cycle pulse on writeback.
REQ-014 illegal_o  output  1  one-cycle pulse on rejected opcode.
REQ-015 timeout_o  output  1  one-cycle pulse on ALU timeout.
REQ-016 dbg_addr_i  input  3 / dbg_data_o  output  DATA_W  combinational register-file read port.

Function
REQ-017 Opcode encoding: NOT=0, AND=1, OR=2, XOR=3, ADD=4, SUB=5, MUL=6, DIV=7, INC=8, DEC=9; 10-31 illegal.
REQ-018 Internal register file: 8 x DATA_W; r0 reads 0, writes to r0 discarded.
REQ-019 FSM states IDLE, REQ, WB; instr_ready_o = 1 only in IDLE.
REQ-020 Accept on instr_valid_i & instr_ready_o; fields latched same edge.
REQ-021 Legal opcode: IDLE->REQ; illegal: stay IDLE, illegal_o pulses next cycle, no ALU request, no write.
REQ-022 REQ: alu_req_o=1, alu_op_o=opcode, alu_a_o=rf[rs1], alu_b_o=rf[rs2]; all stable until ack.
REQ-023 NOT, INC, DEC: alu_b_o = 0.
REQ-024 Outside REQ: alu_req_o=0, alu_op_o=0, alu_a_o=0, alu_b_o=0.
REQ-025 alu_ack_i in REQ: capture alu_result_i, go WB; alu_ack_i outside REQ ignored.
REQ-026 WB: rf[rd] written at end of cycle, done_o=1, next state IDLE.
REQ-027 Minimum latency: accept edge T, alu_req_o high cycle T+1, ack at T+1 -> done_o at T+2, instr_ready_o at T+3.
REQ-028 Back-to-back dependent instructions read updated value (write completes before next accept).
REQ-029 No overflow/flag handling; result written as received, DATA_W bits.

Reset
REQ-030 rst: state IDLE, all rf entries 0, captured result 0, timeout counter 0.
REQ-031 Reset outputs: instr_ready_o=1 after reset release, alu_req_o=0, alu_op_o/alu_a_o/alu_b_o=0, done_o=0, illegal_o=0, timeout_o=0.
REQ-032 rst asserted in REQ or WB aborts operation next edge; no writeback, no done_o.

Configuration
REQ-033 Macro ALU_TIMEOUT_EN defined: counter runs in REQ; after TIMEOUT_CYC cycles without ack, alu_req_o drops, timeout_o pulses one cycle, state IDLE, no write.
REQ-034 Ack in the same cycle the count reaches TIMEOUT_CYC wins: normal writeback, no timeout_o.
REQ-035 Macro undefined: REQ waits indefinitely, timeout_o tied 0, no counter logic.

Verification
REQ-036 Reset, then dbg_addr_i 0-7 -> dbg_data_o = 0 for all; instr_ready_o = 1.
REQ-037 Preload r1=5, r2=3 (ADD via ALU model), ADD rd=3 rs1=1 rs2=2, ALU model acks next cycle with 8 -> alu_a_o=5, alu_b_o=3, done_o at T+2, rf[3]=8.
REQ-038 INC rd=0 rs1=3 -> alu_b_o=0, done_o pulses, rf[0] remains 0.
REQ-039 Opcode 12 offered -> illegal_o one pulse, alu_req_o never asserted, rf unchanged.
REQ-040 MUL with ack delayed 5 cycles -> alu_req_o/alu_op_o=6/operands stable all 5 cycles, instr_ready_o=0 throughout.
REQ-041 ALU_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> timeout_o pulse after 16 REQ cycles, no write; late ack ignored; rst mid-REQ -> alu_req_o 0 next cycle.
